// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial adder computing a + bcom + m, LSB first, one
// bit per clock under a start/done handshake. bcom arrives already
// complemented upstream; m (add=0 / subtract=1) is used as the carry-in.
// Optional macro SERIAL_ADD_ZERO_FLAG_EN adds a 'zero' result flag output.
module serial_add_unit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] bcom,
   input  logic             m,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
`ifdef SERIAL_ADD_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
   logic             zero_q, zero_d;
`endif

   logic             last_bit;
   logic             s_bit;
   logic             c_next;
   logic             c_msb;

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
         zero_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
         zero_q   <= zero_d;
`endif
      end
   end

   // Next-state logic: start is only honoured in IDLE, DONE lasts one cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)    state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:                  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Full-adder slice, operand capture, shifting and result commit.
   always_comb begin
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      zero_d   = zero_q;
`endif
      last_bit = (cnt_q == CNT_W'(WIDTH - 1));
      s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      c_next   = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
      // Carry into the MSB is simply the carry held while the last bit is added.
      c_msb    = carry_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = bcom;
               carry_d  = m;
               cnt_d    = '0;
               sum_sh_d = '0;
            end
         end
         SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = {s_bit, sum_sh_q[WIDTH-1:1]};
            carry_d  = c_next;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_bit) begin
               sum_d  = sum_sh_d;
               cout_d = c_next;
               ovf_d  = c_msb ^ c_next;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
               zero_d = (sum_sh_d == '0);
`endif
            end
         end
         default: ;
      endcase
   end

   // Handshake outputs decoded from state; results come straight from flops.
   always_comb begin
      busy = (state_q == SHIFT);
      done = (state_q == DONE);
      sum  = sum_q;
      cout = cout_q;
      ovf  = ovf_q;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      zero = zero_q;
`endif
   end

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed self-checking bench for serial_add_unit (WIDTH=4).
module tb_serial_add_unit;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] bcom;
   logic             m;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
   logic             zero;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   serial_add_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .bcom  (bcom),
      .m     (m),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      ,
      .zero  (zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag, input logic [3:0] e_sum,
                                     input logic e_cout, input logic e_ovf);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_sum"},  32'(sum),  32'(e_sum));
      check({tag, "_cout"}, 32'(cout), 32'(e_cout));
      check({tag, "_ovf"},  32'(ovf),  32'(e_ovf));
   endtask

   // Full operation: start pulse, WIDTH busy cycles, one-cycle done, results.
   task automatic run_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                         input logic im, input logic [3:0] e_sum, input logic e_cout,
                         input logic e_ovf);
      @(negedge clk);
      a = ia; bcom = ib; m = im; start = 1'b1;
      @(posedge clk); #1;
      check({tag, "_busy0"}, 32'(busy), 32'd1);
      start = 1'b0;
      a = ~ia; bcom = ~ib; m = ~im;
      for (int i = 1; i < int'(WIDTH); i++) begin
         @(posedge clk); #1;
         check({tag, "_busyN"}, 32'(busy), 32'd1);
         check({tag, "_nodone"}, 32'(done), 32'd0);
      end
      @(posedge clk); #1;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_sum"}, 32'(sum), 32'(e_sum));
      check({tag, "_cout"}, 32'(cout), 32'(e_cout));
      check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      check({tag, "_zero"}, 32'(zero), 32'(e_sum == 4'd0));
`endif
      @(posedge clk); #1;
      check({tag, "_done_drop"}, 32'(done), 32'd0);
      check({tag, "_sum_hold"}, 32'(sum), 32'(e_sum));
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; bcom = '0; m = 1'b0;
      #1;
      check_idle_outputs("reset", 4'd0, 1'b0, 1'b0);
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      check("reset_zero", 32'(zero), 32'd0);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("idle", 4'd0, 1'b0, 1'b0);

      run_op("add_3_5",   4'd3, 4'd5,     1'b0, 4'd8,  1'b0, 1'b1);
      run_op("sub_7_2",   4'd7, 4'b1101,  1'b1, 4'd5,  1'b1, 1'b0);
      run_op("sub_0_1",   4'd0, 4'b1110,  1'b1, 4'd15, 1'b0, 1'b0);
      run_op("sub_n8_1",  4'd8, 4'b1110,  1'b1, 4'd7,  1'b1, 1'b1);

      // start re-pulsed mid-SHIFT must be ignored
      @(negedge clk);
      a = 4'd3; bcom = 4'd5; m = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'd7; bcom = 4'b1101; m = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check("restart_notyet", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("restart_done", 32'(done), 32'd1);
      check("restart_sum", 32'(sum), 32'd8);
      check("restart_cout", 32'(cout), 32'd0);
      check("restart_ovf", 32'(ovf), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("restart_single_done", 32'(done), 32'd0);
         check("restart_no_busy", 32'(busy), 32'd0);
      end

      // start held high: re-accepted on the first IDLE edge after DONE
      @(negedge clk);
      a = 4'd0; bcom = 4'b1110; m = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      check("held_busy0", 32'(busy), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("held_done", 32'(done), 32'd1);
      check("held_sum", 32'(sum), 32'd15);
      @(posedge clk); #1;
      check("held_idle_busy", 32'(busy), 32'd0);
      check("held_idle_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("held_reaccept", 32'(busy), 32'd1);
      start = 1'b0;
      a = 4'd3; bcom = 4'd5; m = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("held2_done", 32'(done), 32'd1);
      check("held2_sum", 32'(sum), 32'd15);
      @(posedge clk); #1;

      // reset two cycles into SHIFT aborts immediately
      @(negedge clk);
      a = 4'd7; bcom = 4'b1101; m = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_mid", 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("rst_hold_done", 32'(done), 32'd0);
         if (i == 1) begin
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      check_idle_outputs("post_rst", 4'd0, 1'b0, 1'b0);

      run_op("sub_5_5", 4'd5, 4'b1010, 1'b1, 4'd0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
